// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: word size, canonical NOP, PC step and the
// fetch-queue entry layout.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; the head word is visible
// combinationally so a push in cycle N is poppable in cycle N+1.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // A write into a full FIFO is legal only when the head leaves the same cycle.
  assign w_rd = pop & ~empty;
  assign w_wr = push & (~full | w_rd);

  always_ff @(posedge clk) begin
    if (w_wr && !flush) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetches, in-order response
// buffering and redirect flush. FETCH_QUEUE_BYPASS_EN adds empty-queue forwarding.
module fetch_queue
  import rv32_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $bits(fetch_entry_t);
  localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(DEPTH);

  logic            r_rst_q;
  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_rpc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_out_next;
  logic [CW-1:0]   w_count;
  logic            w_credit;
  logic            w_grant;
  logic            w_discard_zero;
  logic            w_accept;
  logic            w_drop;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  fetch_entry_t    w_wr_entry;
  fetch_entry_t    w_head;
  logic [EW-1:0]   w_head_bits;

  // Queued entries plus in-flight requests never exceed DEPTH.
  assign w_credit = ({1'b0, w_count} + {1'b0, r_outstanding}) < DEPTH_SUM;
  assign mem_req  = ~r_rst_q & w_credit;
  assign mem_addr = r_fpc;
  assign w_grant  = mem_req & mem_gnt;

  assign w_discard_zero = (r_discard == '0);
  assign w_accept       = mem_rvalid & w_discard_zero & ~redirect;
  assign w_drop         = mem_rvalid & ~w_discard_zero;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & w_discard_zero & mem_rvalid & instr_ready & ~redirect;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_wr_entry = '{instr: mem_rdata, pc: r_rpc};
  assign w_push     = w_accept & ~w_bypass & (~w_full | w_pop);
  assign w_pop      = instr_ready & ~w_empty & ~redirect;
  assign w_head     = fetch_entry_t'(w_head_bits);

  always_comb begin
    w_out_next = r_outstanding;
    case ({w_grant, mem_rvalid})
      2'b10:   w_out_next = r_outstanding + 1'b1;
      2'b01:   w_out_next = r_outstanding - 1'b1;
      default: w_out_next = r_outstanding;
    endcase
  end

  always_comb begin
    instr_valid = 1'b0;
    instr       = INSTR_NOP;
    instr_pc    = '0;
    if (w_bypass) begin
      instr_valid = 1'b1;
      instr       = mem_rdata;
      instr_pc    = r_rpc;
    end else if (!w_empty) begin
      instr_valid = 1'b1;
      instr       = w_head.instr;
      instr_pc    = w_head.pc;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (w_push),
    .wdata (w_wr_entry),
    .pop   (w_pop),
    .rdata (w_head_bits),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst) begin
      r_fpc         <= RESET_PC;
      r_rpc         <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fpc     <= redirect_pc;
        r_rpc     <= redirect_pc;
        r_discard <= w_out_next;
      end else begin
        if (w_grant)  r_fpc     <= r_fpc + PC_STEP;
        if (w_accept) r_rpc     <= r_rpc + PC_STEP;
        if (w_drop)   r_discard <= r_discard - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order memory model of configurable latency.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int FIRST = BYP ? 2 : 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  // Memory contents: each word is the bitwise inverse of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic drive(input bit gnt, input bit rdy, input bit redir, input logic [31:0] tgt);
    mem_gnt     = gnt;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = tgt;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend[0].addr);
      pend.delete(0);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    #1;
  endtask

  task automatic step();
    if (mem_req === 1'b1 && mem_gnt) pend.push_back('{mem_addr, cyc + mem_lat});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend.delete();
    repeat (2) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      step();
    end
    rst = 1'b0;
    pend.delete();
  endtask

  task automatic collect(input int n);
    got_pc.delete();
    got_in.delete();
    for (int k = 0; k < 60 && got_pc.size() < n; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (instr_valid === 1'b1) begin
        got_pc.push_back(instr_pc);
        got_in.push_back(instr);
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++;
    if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
    checks++;
    if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 00000000", instr_pc); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    mem_lat = 1;
    for (int j = 0; j < 12; j++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (j == 1) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
          errors++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00000000", mem_req, mem_addr);
        end
      end
      checks++;
      if (instr_valid !== (j >= FIRST)) begin
        errors++; $display("FAIL stream_valid_c%0d: got %b expected %b", j, instr_valid, (j >= FIRST));
      end
      if (j >= FIRST) begin
        exp_pc = 32'(4 * (j - FIRST));
        checks++;
        if (instr_pc !== exp_pc || instr !== ~exp_pc) begin
          errors++; $display("FAIL stream_pc_c%0d: got pc=%h instr=%h expected pc=%h instr=%h", j, instr_pc, instr, exp_pc, ~exp_pc);
        end
      end
      step();
    end
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    int ngrant = 0;
    logic [31:0] exp_pc;
    do_reset();
    mem_lat = 1;
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      if (mem_req === 1'b1) ngrant++;
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (ngrant !== 4) begin errors++; $display("FAIL bp_grants: got %0d expected 4", ngrant); end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_held: got %b expected 0", mem_req); end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=00000000", instr_valid, instr_pc);
    end
    step();
    collect(6);
    checks++;
    if (got_pc.size() != 6) begin errors++; $display("FAIL bp_timeout: got %0d pops expected 6", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      exp_pc = 32'(4 * i);
      checks++;
      if (got_pc[i] !== exp_pc || got_in[i] !== ~exp_pc) begin
        errors++; $display("FAIL bp_pop%0d: got pc=%h instr=%h expected pc=%h instr=%h", i, got_pc[i], got_in[i], exp_pc, ~exp_pc);
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_redirect_outstanding();
    logic [31:0] exp_pc;
    do_reset();
    mem_lat = 3;
    repeat (3) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (mem_addr !== 32'h0000_0100 || mem_req !== 1'b1) begin
      errors++; $display("FAIL redir_addr: got req=%b addr=%h expected req=1 addr=00000100", mem_req, mem_addr);
    end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", instr_valid); end
    step();
    collect(3);
    checks++;
    if (got_pc.size() != 3) begin errors++; $display("FAIL redir_timeout: got %0d pops expected 3", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      exp_pc = 32'h0000_0100 + 32'(4 * i);
      checks++;
      if (got_pc[i] !== exp_pc || got_in[i] !== ~exp_pc) begin
        errors++; $display("FAIL redir_pop%0d: got pc=%h instr=%h expected pc=%h instr=%h", i, got_pc[i], got_in[i], exp_pc, ~exp_pc);
      end
    end
    $display("test_redirect_outstanding done");
  endtask

  task automatic test_redirect_same_cycle();
    logic [31:0] exp_pc;
    do_reset();
    mem_lat = 1;
    repeat (5) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL same_flush: got %b expected 0", instr_valid); end
    checks++;
    if (mem_addr !== 32'h0000_0200) begin errors++; $display("FAIL same_addr: got %h expected 00000200", mem_addr); end
    step();
    collect(3);
    checks++;
    if (got_pc.size() != 3) begin errors++; $display("FAIL same_timeout: got %0d pops expected 3", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      exp_pc = 32'h0000_0200 + 32'(4 * i);
      checks++;
      if (got_pc[i] !== exp_pc || got_in[i] !== ~exp_pc) begin
        errors++; $display("FAIL same_pop%0d: got pc=%h instr=%h expected pc=%h instr=%h", i, got_pc[i], got_in[i], exp_pc, ~exp_pc);
      end
    end
    $display("test_redirect_same_cycle done");
  endtask

  task automatic test_redirect_during_discard();
    logic [31:0] exp_pc;
    do_reset();
    mem_lat = 3;
    repeat (3) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    step();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (mem_addr !== 32'h0000_0300) begin errors++; $display("FAIL disc_addr: got %h expected 00000300", mem_addr); end
    step();
    collect(2);
    checks++;
    if (got_pc.size() != 2) begin errors++; $display("FAIL disc_timeout: got %0d pops expected 2", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      exp_pc = 32'h0000_0300 + 32'(4 * i);
      checks++;
      if (got_pc[i] !== exp_pc || got_in[i] !== ~exp_pc) begin
        errors++; $display("FAIL disc_pop%0d: got pc=%h instr=%h expected pc=%h instr=%h", i, got_pc[i], got_in[i], exp_pc, ~exp_pc);
      end
    end
    $display("test_redirect_during_discard done");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFFC;
    exp_pc[1] = 32'h0000_0000;
    exp_pc[2] = 32'h0000_0004;
    do_reset();
    mem_lat = 1;
    repeat (3) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    collect(3);
    checks++;
    if (got_pc.size() != 3) begin errors++; $display("FAIL wrap_timeout: got %0d pops expected 3", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== exp_pc[i] || got_in[i] !== ~exp_pc[i]) begin
        errors++; $display("FAIL wrap_pop%0d: got pc=%h instr=%h expected pc=%h instr=%h", i, got_pc[i], got_in[i], exp_pc[i], ~exp_pc[i]);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_latency();
    do_reset();
    mem_lat = 1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (instr_valid !== BYP) begin errors++; $display("FAIL lat_rsp_cycle: got %b expected %b", instr_valid, BYP); end
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (instr_valid !== !BYP) begin errors++; $display("FAIL lat_next_cycle: got %b expected %b", instr_valid, !BYP); end
    if (!BYP) begin
      checks++;
      if (instr_pc !== 32'h0 || instr !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL lat_entry: got pc=%h instr=%h expected pc=00000000 instr=ffffffff", instr_pc, instr);
      end
    end
    step();
    $display("test_latency done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_redirect_during_discard();
    test_wrap();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction memory port and the core's PC/decode front end. Issues sequential word fetches to memory through a request/grant/response handshake and buffers up to DEPTH returned instructions with their PCs. Presents them to decode under valid/ready. Handles branch redirects from execute by flushing the queue and discarding in-flight responses.

## Interface
- DEPTH, 4: queue entries; also the maximum number of outstanding memory requests. Power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect  in  1  taken branch/jump from execute (pc_sel).
- redirect_pc  in  32  new fetch target (ALU output); sampled when redirect=1.
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  fetch word address, byte-addressed, bits[1:0]=0.
- mem_gnt  in  1  request accepted this cycle when mem_req=1.
- mem_rvalid  in  1  response valid; responses return in request order.
- mem_rdata  in  32  instruction word.
- instr_valid  out  1  queue head valid.
- instr  out  32  head instruction; NOP (32'h0000_0013) when instr_valid=0.
- instr_pc  out  32  head PC; 0 when instr_valid=0.
- instr_ready  in  1  decode accepts the head (driven as !stall).

## Operation
- Fetch counter fpc: reset to RESET_PC. Advances by +4 (mod 2^32, wraps silently) on each grant (mem_req & mem_gnt).
- Credit rule: mem_req = !rst_q & (count + outstanding < DEPTH). Neither counter can exceed DEPTH. Both counters are $clog2(DEPTH+1) bits wide.
- mem_addr = fpc. It is held stable while mem_req & !mem_gnt, except across a redirect.
- outstanding: +1 on grant, -1 on mem_rvalid. Both in the same cycle leaves it unchanged.
- Response without discard pending: the entry {mem_rdata, pc} is pushed. pc is taken from a response-PC counter rpc, which advances +4 per accepted response.
- Pop: instr_valid & instr_ready. Push and pop in the same cycle are allowed at any fill level, including full.
- Redirect cycle:
  - The queue is emptied and instr_valid=0 from the next cycle.
  - fpc and rpc are loaded with redirect_pc.
  - discard is loaded with outstanding plus the grant in this cycle, minus the response in this cycle.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle is ignored, because decode is being flushed.
- Discard: while discard>0, each mem_rvalid decrements discard and outstanding, and no push occurs. mem_req remains governed by the credit rule, so new requests to the redirect target may issue while stale responses drain.
- Redirect during discard: discard is reloaded per the rule above and stale responses keep being dropped.
- Reset mid-operation clears the queue, outstanding, and discard. The memory shares rst, so no responses arrive for pre-reset requests.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC.
  - instr_valid=0, instr=NOP, instr_pc=0.
  - count=outstanding=discard=0.
- First cycle after rst falls: mem_req=1, mem_addr=RESET_PC.
- Response-to-output latency: mem_rvalid in cycle N gives instr_valid in cycle N+1 (registered queue).
- Throughput: one instruction per cycle with single-cycle memory and instr_ready held high.
- Redirect → mem_addr=redirect_pc in the next cycle; first new instr_valid no earlier than grant + memory latency + 1.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When the queue is empty, discard=0, mem_rvalid=1, instr_ready=1 and there is no redirect, the response appears on instr/instr_pc with instr_valid=1 in the same cycle and is not pushed.
  - Latency becomes 0 cycles.
  - The credit rule is unchanged.
- Undefined: all responses pass through the queue with latency 1.

## Structure
- Shared package rv32_pkg:
  - XLEN=32.
  - INSTR_NOP=32'h0000_0013.
  - a fetch-entry struct {instr, pc}.
  - PC_STEP=4.
- Sub-module sync_fifo, parameterised by width and depth:
  - storage plus read/write pointers (wrap mod DEPTH), count, full/empty, and a synchronous flush input.
  - fetch_queue contains the credit, discard, and PC logic around it.

## Test plan
- Stream:
  - Stimulus: rst for 2 cycles; mem_gnt=1; rvalid one cycle after grant; instr_ready=1.
  - Response: instr_pc 0x0, 0x4, 0x8, … on consecutive cycles. The first instr_valid comes 3 cycles after rst falls.
- Backpressure:
  - Stimulus: instr_ready=0, then release.
  - Response: mem_req drops once count+outstanding=4. Exactly 4 entries are held. On release they pop in order 0x0–0xC with no loss or duplication.
- Redirect with 2 outstanding:
  - Stimulus: redirect_pc=0x100.
  - Response: the next two responses are dropped. mem_addr=0x100 next cycle. The first valid instr_pc=0x100.
- Redirect in the same cycle as grant and rvalid:
  - Response: discard = outstanding+1-1. The grant's response is dropped. No stale PC ever reaches decode.
- Wrap:
  - Stimulus: redirect_pc=0xFFFF_FFFC.
  - Response: instr_pc 0xFFFF_FFFC then 0x0000_0000.
- Bypass (FETCH_QUEUE_BYPASS_EN defined):
  - Stimulus: queue empty, rvalid at cycle N.
  - Response: instr_valid in cycle N. With the macro undefined, it appears in cycle N+1.
